// File: rtl/vga_grid_renderer.sv
// VGA timing generator drawing a ROWS x COLS grid of white cells with one coloured
// marker square; frame inputs are sampled once per frame and outputs are 2-stage pipelined.
module vga_grid_renderer #(
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int CELL       = 120,
  parameter int GAP        = 5,
  parameter int MARK       = 60,
  parameter int ORIGIN_X   = 136,
  parameter int ORIGIN_Y   = 45,
  parameter int CW         = 4,
  parameter int HIT_FRAMES = 16,
  parameter int PW         = 4
) (
  input  logic          clk25MHz,
  input  logic          rst,
  input  logic          in_game,
  input  logic          hit,
  input  logic [PW-1:0] position,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [CW-1:0] o_red,
  output logic [CW-1:0] o_green,
  output logic [CW-1:0] o_blue,
  output logic          o_frame_start,
  output logic          o_active
);

  localparam int XW    = $clog2(H_TOTAL);
  localparam int YW    = $clog2(V_TOTAL);
  localparam int FW    = $clog2(HIT_FRAMES + 1);
  localparam int X0    = H_SYNC + H_BP;
  localparam int Y0    = V_SYNC + V_BP;
  localparam int PITCH = CELL + GAP;
  localparam int MOFF  = (CELL - MARK) / 2;

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic [31:0]   xi;
  logic [31:0]   yi;
  logic          frame_start_raw;

  logic          in_game_reg;
  logic [PW-1:0] pos_reg;
  logic [FW-1:0] flash_reg;
  logic [FW-1:0] flash_next;

  logic [COLS-1:0]      col_in;
  logic [COLS-1:0]      col_mark;
  logic [ROWS-1:0]      row_in;
  logic [ROWS-1:0]      row_mark;
  logic [ROWS*COLS-1:0] mark_cell;
  logic                 active_raw;

  logic hsync_p1_reg, vsync_p1_reg, fs_p1_reg, active_p1_reg;
  logic cell_p1_reg, mark_p1_reg, flash_p1_reg;
  logic [CW-1:0] red_next, green_next, blue_next;

  assign xi              = 32'(x_reg);
  assign yi              = 32'(y_reg);
  assign frame_start_raw = (x_reg == '0) && (y_reg == '0);

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (x_reg == XW'(H_TOTAL - 1)) begin
      x_reg <= '0;
      y_reg <= (y_reg == YW'(V_TOTAL - 1)) ? '0 : y_reg + YW'(1);
    end else begin
      x_reg <= x_reg + XW'(1);
    end
  end

  // Flash counter follows the values being sampled at this frame start.
  always_comb begin
    flash_next = flash_reg;
    if (!in_game)
      flash_next = '0;
    else if (hit)
      flash_next = FW'(HIT_FRAMES);
    else if (flash_reg != '0)
      flash_next = flash_reg - FW'(1);
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      in_game_reg <= 1'b0;
      pos_reg     <= '0;
      flash_reg   <= '0;
    end else if (frame_start_raw) begin
      in_game_reg <= in_game;
      pos_reg     <= position;
      flash_reg   <= flash_next;
    end
  end

  // Grid geometry expressed directly in counter coordinates.
  genvar gi, gj;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam int CX = X0 + ORIGIN_X + gi * PITCH;
      assign col_in[gi]   = (xi >= 32'(CX)) && (xi < 32'(CX + CELL));
      assign col_mark[gi] = (xi >= 32'(CX + MOFF)) && (xi < 32'(CX + MOFF + MARK));
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam int CY = Y0 + ORIGIN_Y + gi * PITCH;
      assign row_in[gi]   = (yi >= 32'(CY)) && (yi < 32'(CY + CELL));
      assign row_mark[gi] = (yi >= 32'(CY + MOFF)) && (yi < 32'(CY + MOFF + MARK));
    end
    // Positions run bottom-up within a column, columns left to right.
    for (gi = 0; gi < ROWS; gi++) begin : g_mrow
      for (gj = 0; gj < COLS; gj++) begin : g_mcol
        localparam int IDX = gj * ROWS + (ROWS - gi);
        assign mark_cell[gi*COLS+gj] = (pos_reg == PW'(IDX)) && row_mark[gi] && col_mark[gj];
      end
    end
  endgenerate

  assign active_raw = (xi >= 32'(X0)) && (xi < 32'(X0 + H_ACTIVE)) &&
                      (yi >= 32'(Y0)) && (yi < 32'(Y0 + V_ACTIVE));

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      hsync_p1_reg  <= 1'b0;
      vsync_p1_reg  <= 1'b0;
      fs_p1_reg     <= 1'b0;
      active_p1_reg <= 1'b0;
      cell_p1_reg   <= 1'b0;
      mark_p1_reg   <= 1'b0;
      flash_p1_reg  <= 1'b0;
    end else begin
      hsync_p1_reg  <= xi < 32'(H_SYNC);
      vsync_p1_reg  <= yi < 32'(V_SYNC);
      fs_p1_reg     <= frame_start_raw;
      active_p1_reg <= active_raw;
      cell_p1_reg   <= active_raw && (|col_in) && (|row_in);
      mark_p1_reg   <= active_raw && in_game_reg && (|mark_cell);
      flash_p1_reg  <= flash_reg != '0;
    end
  end

  always_comb begin
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (mark_p1_reg) begin
      if (flash_p1_reg)
        red_next = '1;
      else
        green_next = '1;
    end else if (cell_p1_reg) begin
      red_next   = '1;
      green_next = '1;
      blue_next  = '1;
    end
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_frame_start <= 1'b0;
      o_active      <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      o_hsync       <= hsync_p1_reg;
      o_vsync       <= vsync_p1_reg;
      o_frame_start <= fs_p1_reg;
      o_active      <= active_p1_reg;
      o_red         <= red_next;
      o_green       <= green_next;
      o_blue        <= blue_next;
    end
  end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Bench for vga_grid_renderer on a shrunken raster; every cycle is compared against
// a pixel model built from frame/line arithmetic and per-frame sampled inputs.
module tb_vga_grid_renderer;

  localparam int HS = 4, HBP = 3, HA = 40, HT = 52;
  localparam int VS = 2, VBP = 2, VA = 30, VT = 36;
  localparam int ROWS = 3, COLS = 3, CELL = 8, GAP = 2, MARK = 4, OX = 3, OY = 2;
  localparam int CW = 4, HF = 4, PW = 4;
  localparam int FRAME = HT * VT;
  localparam int PITCH = CELL + GAP;
  localparam int MOFF  = (CELL - MARK) / 2;
  localparam logic [CW-1:0]   ONES  = '1;
  localparam logic [CW-1:0]   ZERO  = '0;
  localparam logic [3*CW-1:0] WHITE = {ONES, ONES, ONES};
  localparam logic [3*CW-1:0] GREEN = {ZERO, ONES, ZERO};
  localparam logic [3*CW-1:0] RED   = {ONES, ZERO, ZERO};

  logic          clk25MHz = 1'b0;
  logic          rst      = 1'b1;
  logic          in_game  = 1'b0;
  logic          hit      = 1'b0;
  logic [PW-1:0] position = '0;
  logic          o_hsync, o_vsync, o_frame_start, o_active;
  logic [CW-1:0] o_red, o_green, o_blue;

  logic [3+3*CW:0] obs, exp_vec;
  int total = 0, passed = 0;
  int n = 0;
  bit m_ig;
  int m_pos, m_flash;
  int exp_ax, exp_ay;

  assign obs = {o_hsync, o_vsync, o_frame_start, o_active, o_red, o_green, o_blue};

  vga_grid_renderer #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
    .ROWS(ROWS), .COLS(COLS), .CELL(CELL), .GAP(GAP), .MARK(MARK),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .CW(CW), .HIT_FRAMES(HF), .PW(PW)
  ) dut (
    .clk25MHz(clk25MHz), .rst(rst), .in_game(in_game), .hit(hit), .position(position),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_red(o_red), .o_green(o_green),
    .o_blue(o_blue), .o_frame_start(o_frame_start), .o_active(o_active)
  );

  always #20 clk25MHz = ~clk25MHz;

  task automatic reset_model();
    n = 0; m_ig = 1'b0; m_pos = 0; m_flash = 0;
  endtask

  // One clock: sample inputs at frame boundaries, advance, then predict outputs.
  task automatic step();
    int c, x, y, px, py, cc, rr, lx, ly;
    logic [CW-1:0] r, g, b;
    if (n % FRAME == 0) begin
      m_ig  = in_game;
      m_pos = int'(position);
      if (!in_game) m_flash = 0;
      else if (hit) m_flash = HF;
      else if (m_flash > 0) m_flash = m_flash - 1;
    end
    @(posedge clk25MHz);
    n++;
    @(negedge clk25MHz);
    exp_vec = '0; exp_ax = -1; exp_ay = -1;
    if (n >= 2) begin
      c = n - 2; x = c % HT; y = (c / HT) % VT;
      r = '0; g = '0; b = '0;
      if (x >= HS + HBP && x < HS + HBP + HA && y >= VS + VBP && y < VS + VBP + VA) begin
        exp_ax = x - HS - HBP; exp_ay = y - VS - VBP;
        px = exp_ax - OX; py = exp_ay - OY;
        if (px >= 0 && py >= 0 && px < COLS * PITCH && py < ROWS * PITCH &&
            px % PITCH < CELL && py % PITCH < CELL) begin
          cc = px / PITCH; rr = py / PITCH; lx = px % PITCH; ly = py % PITCH;
          r = ONES; g = ONES; b = ONES;
          if (m_ig && m_pos >= 1 && m_pos <= ROWS * COLS &&
              cc == (m_pos - 1) / ROWS && rr == ROWS - 1 - (m_pos - 1) % ROWS &&
              lx >= MOFF && lx < MOFF + MARK && ly >= MOFF && ly < MOFF + MARK) begin
            b = '0;
            if (m_flash > 0) g = '0; else r = '0;
          end
        end
      end
      exp_vec = {x < HS, y < VS, (x == 0 && y == 0), exp_ax >= 0, r, g, b};
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #4;
    total++; if (obs === '0) passed++; else $display("FAIL reset_state got %h expected 0", obs);
    repeat (3) @(posedge clk25MHz);
    @(negedge clk25MHz);
    rst = 1'b1; reset_model();
    repeat (FRAME + 4) begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL reset_run n=%0d got %h expected %h", n, obs, exp_vec);
      if (n == 2) begin
        total++; if (o_frame_start === 1'b1) passed++;
        else $display("FAIL first_frame_start got %b expected 1", o_frame_start);
      end
    end
  endtask

  task automatic test_sync_timing();
    int hs_rise = -1, vs_rise = -1, fs_last = -1;
    logic p_hs, p_vs;
    p_hs = o_hsync; p_vs = o_vsync;
    repeat (2 * FRAME + 4) begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL sync_pixel n=%0d got %h expected %h", n, obs, exp_vec);
      if (o_hsync && !p_hs) begin
        if (hs_rise >= 0) begin
          total++; if (n - hs_rise == HT) passed++;
          else $display("FAIL hsync_period got %0d expected %0d", n - hs_rise, HT);
        end
        hs_rise = n;
      end
      if (!o_hsync && p_hs && hs_rise >= 0) begin
        total++; if (n - hs_rise == HS) passed++;
        else $display("FAIL hsync_width got %0d expected %0d", n - hs_rise, HS);
      end
      if (o_vsync && !p_vs) begin
        if (vs_rise >= 0) begin
          total++; if (n - vs_rise == FRAME) passed++;
          else $display("FAIL vsync_period got %0d expected %0d", n - vs_rise, FRAME);
        end
        vs_rise = n;
      end
      if (!o_vsync && p_vs && vs_rise >= 0) begin
        total++; if (n - vs_rise == VS * HT) passed++;
        else $display("FAIL vsync_width got %0d expected %0d", n - vs_rise, VS * HT);
      end
      if (o_frame_start) begin
        if (fs_last >= 0) begin
          total++; if (n - fs_last == FRAME) passed++;
          else $display("FAIL frame_start_period got %0d expected %0d", n - fs_last, FRAME);
        end
        fs_last = n;
      end
      p_hs = o_hsync; p_vs = o_vsync;
    end
  endtask

  task automatic test_grid_marker();
    int bnd;
    in_game = 1'b1; position = 4'd1; hit = 1'b0;
    bnd = n + (FRAME - n % FRAME) % FRAME;
    while (n - 2 < bnd + FRAME) begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL grid_pixel n=%0d got %h expected %h", n, obs, exp_vec);
      if (n - 2 > bnd && exp_ay == OY + 2 * PITCH + MOFF) begin
        if (exp_ax == OX + MOFF) begin
          total++; if (obs[3*CW-1:0] === GREEN) passed++;
          else $display("FAIL marker_corner got %h expected %h", obs[3*CW-1:0], GREEN);
        end
        if (exp_ax == OX + 1) begin
          total++; if (obs[3*CW-1:0] === WHITE) passed++;
          else $display("FAIL cell_white got %h expected %h", obs[3*CW-1:0], WHITE);
        end
        if (exp_ax == OX - 1 || exp_ax == OX + CELL) begin
          total++; if (obs[3*CW-1:0] === '0) passed++;
          else $display("FAIL outside_black ax=%0d got %h expected 0", exp_ax, obs[3*CW-1:0]);
        end
      end
    end
  endtask

  task automatic test_mid_frame_change();
    int f_cur, fr;
    in_game = 1'b1; position = 4'd1; hit = 1'b0;
    do begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL midframe_pre n=%0d got %h expected %h", n, obs, exp_vec);
    end while (n % FRAME != 0);
    do begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL midframe_pre n=%0d got %h expected %h", n, obs, exp_vec);
    end while (n % FRAME != FRAME / 2);
    f_cur = (n - 2) / FRAME;
    position = 4'd9;
    while ((n - 2) / FRAME < f_cur + 2) begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL midframe_pixel n=%0d got %h expected %h", n, obs, exp_vec);
      fr = (n - 2) / FRAME;
      if (fr == f_cur && exp_ax == OX + CELL / 2 && exp_ay == OY + 2 * PITCH + CELL / 2) begin
        total++; if (obs[3*CW-1:0] === GREEN) passed++;
        else $display("FAIL no_tearing got %h expected %h", obs[3*CW-1:0], GREEN);
      end
      if (fr == f_cur + 1 && exp_ax == OX + 2 * PITCH + CELL / 2 && exp_ay == OY + CELL / 2) begin
        total++; if (obs[3*CW-1:0] === GREEN) passed++;
        else $display("FAIL new_marker got %h expected %h", obs[3*CW-1:0], GREEN);
      end
      if (fr == f_cur + 1 && exp_ax == OX + CELL / 2 && exp_ay == OY + 2 * PITCH + CELL / 2) begin
        total++; if (obs[3*CW-1:0] === WHITE) passed++;
        else $display("FAIL old_marker_gone got %h expected %h", obs[3*CW-1:0], WHITE);
      end
    end
  endtask

  task automatic test_hit_flash();
    int n0, k;
    in_game = 1'b1; position = 4'd5; hit = 1'b0;
    while (n % FRAME != FRAME - 5) begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL flash_pre n=%0d got %h expected %h", n, obs, exp_vec);
    end
    hit = 1'b1;
    n0 = n + 5;
    while (n - 2 < n0 + (HF + 2) * FRAME) begin
      step();
      if (n == n0 + 5) hit = 1'b0;
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL flash_pixel n=%0d got %h expected %h", n, obs, exp_vec);
      if (n - 2 > n0 && exp_ax == OX + PITCH + CELL / 2 && exp_ay == OY + PITCH + CELL / 2) begin
        k = (n - 2 - n0) / FRAME;
        total++;
        if (obs[3*CW-1:0] === ((k < HF) ? RED : GREEN)) passed++;
        else $display("FAIL flash_centre frame=%0d got %h expected %h", k, obs[3*CW-1:0],
                      (k < HF) ? RED : GREEN);
      end
    end
  endtask

  task automatic test_no_marker();
    int bnd;
    for (int ph = 0; ph < 2; ph++) begin
      in_game  = (ph == 1);
      position = (ph == 1) ? 4'd10 : 4'd5;
      bnd = n + (FRAME - n % FRAME) % FRAME;
      while (n - 2 < bnd + FRAME) begin
        step();
        total++; if (obs === exp_vec) passed++;
        else $display("FAIL nomark_pixel n=%0d got %h expected %h", n, obs, exp_vec);
        if (n - 2 > bnd && exp_ax == OX + PITCH + CELL / 2 && exp_ay == OY + PITCH + CELL / 2) begin
          total++; if (obs[3*CW-1:0] === WHITE) passed++;
          else $display("FAIL nomark_centre ph=%0d got %h expected %h", ph, obs[3*CW-1:0], WHITE);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (5 * FRAME) begin
      if ($urandom_range(0, 299) == 0) in_game = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) position = PW'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) hit = ~hit;
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL random_pixel n=%0d got %h expected %h", n, obs, exp_vec);
    end
    hit = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    in_game = 1'b1; position = 4'd3; hit = 1'b0;
    do begin
      step();
      guard++;
    end while (!(o_active === 1'b1 && o_red !== '0) && guard < 2 * FRAME);
    total++; if (guard < 2 * FRAME) passed++;
    else $display("FAIL wait_white_pixel got timeout expected lit pixel");
    #3 rst = 1'b0;
    #1;
    total++; if (obs === '0) passed++;
    else $display("FAIL async_clear got %h expected 0", obs);
    @(posedge clk25MHz); #1;
    total++; if (obs === '0) passed++;
    else $display("FAIL held_reset got %h expected 0", obs);
    @(negedge clk25MHz);
    rst = 1'b1; reset_model();
    repeat (FRAME + 4) begin
      step();
      total++; if (obs === exp_vec) passed++;
      else $display("FAIL restart_pixel n=%0d got %h expected %h", n, obs, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_grid_marker();
    test_mid_frame_change();
    test_hit_flash();
    test_no_marker();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_grid_renderer.md
VGA_GRID_RENDERER -- requirements
Module: vga_grid_renderer

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, hsync width in pixel clocks.
REQ-002 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-003 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-005 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-006 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-007 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-008 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-009 SHALL have parameters ROWS and COLS, default 3 each, grid dimensions.
REQ-010 SHALL have parameters CELL 120, GAP 5, MARK 60, ORIGIN_X 136, ORIGIN_Y 45: cell edge, inter-cell gap, centred marker edge, and grid top-left offset in active-area pixels.
REQ-011 SHALL have parameter CW, default 4, colour channel width.
REQ-012 SHALL have parameter HIT_FRAMES, default 16, hit-flash duration in frames.
REQ-013 SHALL have parameter PW, default 4, position width (must satisfy 2^PW > ROWS*COLS).
REQ-014 clk25MHz  in  1  pixel clock.
REQ-015 rst  in  1  reset, asynchronous, active-low.
REQ-016 in_game  in  1  game running; enables marker drawing.
REQ-017 hit  in  1  level; marker reported as hit.
REQ-018 position  in  PW  target cell, 0 = none.
REQ-019 o_hsync, o_vsync  out  1 each  sync, active-high.
REQ-020 o_red, o_green, o_blue  out  CW each  pixel colour.
REQ-021 o_frame_start  out  1  one-cycle pulse at start of each frame.
REQ-022 o_active  out  1  high while colour outputs are in visible area.

Function
REQ-023 x counter SHALL count 0..H_TOTAL-1 and wrap; y SHALL advance when x = H_TOTAL-1, count 0..V_TOTAL-1, wrap.
REQ-024 Raw hsync SHALL be high for x < H_SYNC; raw vsync high for y < V_SYNC.
REQ-025 Visible area SHALL be x in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), y in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE); active coordinates ax, ay SHALL be 0-based within it.
REQ-026 All outputs (sync, active, colour, frame_start) SHALL be registered with exactly 2 clock latency from counter values, sync and colour aligned.
REQ-027 At x=0, y=0 the block SHALL latch in_game, position and hit into frame registers; drawing SHALL use only latched values for the whole frame (no mid-frame tearing).
REQ-028 Cell (r,c), r=0 top, SHALL span ax in [ORIGIN_X + c*(CELL+GAP), +CELL), ay in [ORIGIN_Y + r*(CELL+GAP), +CELL); cell pixels white (all ones); gaps and outside grid black.
REQ-029 Position p in 1..ROWS*COLS SHALL select column (p-1)/ROWS and bottom-up row (p-1)%ROWS, i.e. r = ROWS-1-((p-1)%ROWS).
REQ-030 p = 0 or p > ROWS*COLS SHALL draw no marker.
REQ-031 Marker SHALL be a MARK x MARK square centred in the selected cell, drawn only if latched in_game = 1.
REQ-032 Flash counter SHALL load HIT_FRAMES at frame start when latched hit = 1, else decrement by 1 per frame, saturating at 0.
REQ-033 Marker colour SHALL be red (R all ones, G=B=0) while flash counter > 0, else green (G all ones, R=B=0).
REQ-034 Latched in_game = 0 SHALL clear the flash counter.
REQ-035 Outside visible area o_red/o_green/o_blue SHALL be 0 and o_active 0.

Reset
REQ-036 rst low SHALL asynchronously clear counters, latched frame registers, flash counter, pipeline, and all outputs to 0.
REQ-037 After rst release, first frame_start SHALL occur 2 clocks after the first counter value x=0,y=0.

Verification
REQ-038 Reset then run: o_hsync period 800 clocks, high 96; o_vsync period 420000 clocks, high 1600; o_frame_start once per 420000 clocks.
REQ-039 in_game=1, position=1, hit=0 before frame start -> pixel ax=166, ay=335 green, ax=140, ay=335 white, ax=130 black.
REQ-040 hit pulsed high across one frame start, position=5 -> centre of middle cell red for 16 frames, green from 17th frame.
REQ-041 position changed 1->9 mid-frame -> current frame unchanged; next frame marker at column 2, top row.
REQ-042 in_game=0 or position=10 -> all cells white, no marker.
REQ-043 rst asserted mid-line -> all outputs 0 immediately; after release counters restart from 0,0.
